// File: rtl/seq_detector_param_if.sv
// Serial-stream bundle for seq_detector_param: control and data inputs, match outputs and counter.
// The master side drives the stream. The slave side is the detector.
interface seq_detector_param_if #(
    parameter int CNT_W = 8
);
    logic             clr;
    logic             en;
    logic             inp;
    logic             overlap;
    logic             out;
    logic             out_reg;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output clr, en, inp, overlap,
        input  out, out_reg, match_count, count_sat
    );

    modport slave (
        input  clr, en, inp, overlap,
        output out, out_reg, match_count, count_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector with overlap control, enable, synchronous clear and a registered match copy.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_count and count_sat are tied to 0.
module seq_detector_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
    parameter int                 CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int FILL_W = (PAT_LEN <= 2) ? 1 : $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               out_reg_q, out_reg_d;
    logic               accept;
    logic               match;

    // The newest bit enters at bit 0; a two-bit pattern keeps only one history bit.
    generate
        if (PAT_LEN == 2) begin : g_hist_one
            assign hist_shift = bus.inp;
        end else begin : g_hist_many
            assign hist_shift = {hist_q[PAT_LEN-3:0], bus.inp};
        end
    endgenerate

    assign accept = bus.en & ~bus.clr;
    assign match  = accept & (fill_q == FILL_FULL) & ({hist_q, bus.inp} == PATTERN);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_reg_d = match;
        if (bus.clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = hist_shift;
            // Non-overlapping mode throws away the history that formed the match.
            if (match && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            out_reg_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_reg_q <= out_reg_d;
        end
    end

    assign bus.out     = match;
    assign bus.out_reg = out_reg_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_count = cnt_q;
    assign bus.count_sat   = &cnt_q;
`else
    assign bus.match_count = {CNT_W{1'b0}};
    assign bus.count_sat   = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: three instances (default, 4-bit 1010, 2-bit counter).
// Each driven cycle pushes hand-computed expectations; a monitor pops and compares them mid-cycle.
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_detector_param_if #(.CNT_W(8)) ia ();
    seq_detector_param_if #(.CNT_W(8)) ib ();
    seq_detector_param_if #(.CNT_W(2)) ic ();

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b110), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ia));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ib));
    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b110), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        string tag;
        int    id;
        bit    out;
        bit    oreg;
        int    cnt;
        bit    sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Bench model state: last expected out and matches seen per instance.
    bit   last_out[3];
    int   cnt_m[3];
    int   cnt_max[3] = '{255, 255, 3};

    task automatic chk(input string tag, input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int id, input bit eo);
        exp_t e;
        e.tag  = tag;
        e.id   = id;
        e.out  = eo;
        e.oreg = last_out[id];
`ifdef SEQ_DET_COUNT_EN
        e.cnt  = cnt_m[id];
        e.sat  = (cnt_m[id] == cnt_max[id]);
`else
        e.cnt  = 0;
        e.sat  = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic idle_all();
        ia.en = 1'b0; ia.clr = 1'b0;
        ib.en = 1'b0; ib.clr = 1'b0;
        ic.en = 1'b0; ic.clr = 1'b0;
    endtask

    // One clock of stimulus on one instance, with the hand-computed out for that cycle.
    task automatic step(input string tag, input int id, input bit e, input bit i,
                        input bit ov, input bit c, input bit exp_out);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle_all();
        case (id)
            0: begin ia.en = e; ia.inp = i; ia.overlap = ov; ia.clr = c; end
            1: begin ib.en = e; ib.inp = i; ib.overlap = ov; ib.clr = c; end
            default: begin ic.en = e; ic.inp = i; ic.overlap = ov; ic.clr = c; end
        endcase
        push_exp(tag, id, exp_out);
        if (c) cnt_m[id] = 0;
        else if (exp_out && cnt_m[id] < cnt_max[id]) cnt_m[id]++;
        for (int d = 0; d < 3; d++) last_out[d] = (d == id) ? exp_out : 1'b0;
    endtask

    task automatic run(input string tag, input int id, input bit ov,
                       input bit bits[], input bit outs[]);
        for (int k = 0; k < bits.size(); k++) step(tag, id, 1'b1, bits[k], ov, 1'b0, outs[k]);
    endtask

    task automatic reset_check(input string tag);
        for (int d = 0; d < 3; d++) begin
            last_out[d] = 1'b0;
            cnt_m[d]    = 0;
            push_exp(tag, d, 1'b0);
        end
    endtask

    // Monitor: compares everything pushed for the current cycle once inputs have settled.
    initial begin
        exp_t e;
        bit   a_out, a_oreg, a_sat;
        int   a_cnt;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0: begin a_out = ia.out; a_oreg = ia.out_reg; a_cnt = int'(ia.match_count); a_sat = ia.count_sat; end
                    1: begin a_out = ib.out; a_oreg = ib.out_reg; a_cnt = int'(ib.match_count); a_sat = ib.count_sat; end
                    default: begin a_out = ic.out; a_oreg = ic.out_reg; a_cnt = int'(ic.match_count); a_sat = ic.count_sat; end
                endcase
                chk(e.tag, "out", int'(a_out), int'(e.out));
                chk(e.tag, "out_reg", int'(a_oreg), int'(e.oreg));
                chk(e.tag, "match_count", a_cnt, e.cnt);
                chk(e.tag, "count_sat", int'(a_sat), int'(e.sat));
                $display("chk %-10s dut%0d out=%0b out_reg=%0b cnt=%0d sat=%0b", e.tag, e.id,
                         a_out, a_oreg, a_cnt, a_sat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        ia.inp = 1'b0; ia.overlap = 1'b1;
        ib.inp = 1'b0; ib.overlap = 1'b1;
        ic.inp = 1'b0; ic.overlap = 1'b1;
        for (int d = 0; d < 3; d++) begin last_out[d] = 1'b0; cnt_m[d] = 0; end

        @(negedge clk);
        #1;
        reset_check("por");

        // Overlapping 110 on 0,1,1,0,1,1,1,0: matches on cycles 4 and 8.
        run("ovl110", 0, 1'b1, '{0,1,1,0,1,1,1,0}, '{0,0,0,1,0,0,0,1});
        // Continue: 1,1, disabled 0, then enabled 0 completes 110.
        run("en_pre", 0, 1'b1, '{1,1}, '{0,0});
        step("en_off", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("en_on", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // 1010 overlapping, clear, then non-overlapping.
        run("ovl1010", 1, 1'b1, '{1,0,1,0,1,0,1,0}, '{0,0,0,1,0,1,0,1});
        step("clr1010", 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run("novl1010", 1, 1'b0, '{1,0,1,0,1,0,1,0}, '{0,0,0,1,0,0,0,1});

        // Partial 1,1 then asynchronous reset in mid-cycle; a trailing 0 must not match.
        run("rst_pre", 0, 1'b1, '{1,1}, '{0,0});
        @(negedge clk);
        #1;
        idle_all();
        rst = 1'b1;
        reset_check("rst_mid");
        run("rst_post", 0, 1'b1, '{0,1,1,0}, '{0,0,0,1});

        // Same with clear: count returns to 0 and the pending 1,1 is lost.
        run("clr_pre", 0, 1'b1, '{1,1}, '{0,0});
        step("clr_mid", 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run("clr_post", 0, 1'b1, '{0,0}, '{0,0});

        // Five non-overlapping 110 groups into a 2-bit counter: saturates at 3.
        for (int g = 0; g < 5; g++) run("sat", 2, 1'b0, '{1,1,0}, '{0,0,1});
        run("sat_hold", 2, 1'b0, '{0}, '{0});

        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
